masked_state_tx: RTL and testbench
==================================

# masked_state_tx

Byte-serial transmitter that encodes an unmasked 128-bit AES state into the two-random-bit masked, two-share byte format consumed by the masked round datapath. For each share byte it emits share0 and share1 together with the block mask pair (m0, m1), such that share0 ^ share1 ^ M(m0,m1) equals the plaintext byte. The block sits between the plaintext/key loader and the masked AddRoundKey stage. It is the producing end of the masked-byte interface that the round datapath receives.

## Interface
- NBYTES, 16, bytes per block; byte counter width is clog2(NBYTES).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  block accepted when in_valid && in_ready.
- in_data  in  8*NBYTES  plaintext; byte k = in_data[8k+7:8k]; byte 0 is sent first.
- rnd_mask  in  2  {m1,m0}; sampled once per block on the in handshake.
- rnd_share  in  8  fresh share randomness; sampled whenever a byte register loads.
- out_valid  out  1  masked byte available.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- out_share0, out_share1  out  8 each  registered shares.
- out_m0, out_m1  out  1 each  block mask bits; constant for the whole block.
- out_idx  out  clog2(NBYTES)  index of the current byte.
- out_last  out  1  high when out_idx == NBYTES-1.

## Operation
- Mask pattern M(m0,m1), per bit:
  - bit0 = m1, bit1 = m0^m1, bit2 = m0^m1, bit3 = m0;
  - bit4 = m0, bit5 = m1, bit6 = m0, bit7 = m1.
  - Resulting values: M(1,0) = 0x5E, M(0,1) = 0xA7, M(1,1) = 0xF9, M(0,0) = 0x00.
- FSM has two states.
  - IDLE: in_ready = 1, out_valid = 0. An in handshake captures in_data into the block register and rnd_mask into the mask register, loads byte 0, and moves to SEND.
  - SEND: out_valid = 1. An out handshake with out_last = 0 loads byte idx+1. An out handshake with out_last = 1 returns the FSM to IDLE.
- Byte load:
  - share1 <= rnd_share.
  - share0 <= data_byte ^ M(m) ^ rnd_share.
- Shares are computed by a single XOR level from registered values only. No combinational path runs from in_data or rnd_share to the outputs.
- Unmasked data must never appear on any output port. The full M(m) is applied before the register.
- The plaintext register is cleared to 0 on the transition SEND→IDLE. This limits how long unmasked data stays resident.
- in_ready = 0 in SEND. A new block is never overlapped with the current one.

## Timing
- Reset (rst high at an edge) forces state IDLE and clears all registers. All outputs read 0, except in_ready = 1 from the first cycle after reset is released. While rst is high, in_ready = 0.
- Latency: in handshake at edge t gives byte 0 with out_valid = 1 after edge t.
- Throughput: 1 byte/cycle when out_ready is held high, with no bubbles between bytes.
- A block takes NBYTES cycles in SEND. After the last handshake, in_ready = 1 in the next cycle, so there is one idle cycle between blocks.
- Backpressure: while out_valid && !out_ready, every output holds stable and rnd_share is ignored.
- out_m0/out_m1 stay stable from byte 0 through the last byte. They are 0 in IDLE.
- Reset in SEND aborts the block. Outputs return to reset values and the remaining bytes are discarded.
- in_valid in SEND is ignored. The source must hold its block until in_ready.

## Structure
- Package masked_aes_pkg holds:
  - the NBYTES default;
  - the per-bit mask selector constant (bits 3,4,6 → m0; bits 0,5,7 → m1; bits 1,2 → m0^m1);
  - function mask_pattern(m0,m1) returning 8 bits;
  - the state enum {IDLE, SEND}.
- Sub-module masked_byte_encoder (combinational; ports data, rnd, m0, m1 → share0, share1) is reused by the key-side loader. The top level holds the FSM, counter and registers.

## Test plan
- Block 0x0F0E…0100, rnd_mask = 2'b01 (m0 = 1), rnd_share = 0x00, out_ready = 1:
  - 16 consecutive bytes, share0 = k ^ 0x5E, share1 = 0x00;
  - out_last only on idx 15; in_ready returns 1 cycle later.
- Same block with rnd_mask = 2'b10 and then 2'b11 → share0 ^ share1 = k ^ 0xA7 and k ^ 0xF9 respectively, for random rnd_share.
- out_ready toggled pseudo-randomly, with rnd_share changing every cycle → outputs stable during stall, no byte dropped or duplicated, and share0 ^ share1 ^ M reconstructs every plaintext byte.
- in_valid held high during SEND with a different in_data → ignored; the second block is accepted only after the first block's idx 15 handshake.
- rst asserted after byte 5 → next cycle out_valid = 0, all outputs 0, in_ready = 1; the next block starts at idx 0.
- Scoreboard check over 1000 random blocks: no output port ever carries the plaintext byte while its mask is nonzero, and the plaintext register reads 0 in IDLE.

Source files
------------

// File: rtl/masked_aes_pkg.sv
// Shared constants, mask pattern and state type for the masked AES byte path.
package masked_aes_pkg;

   localparam int NBYTES_DEFAULT = 16;

   // Per-bit mask selectors: m0 drives bits 1,2,3,4,6 and m1 drives bits 0,1,2,5,7,
   // so bits 1 and 2 carry m0^m1.
   localparam logic [7:0] MASK_SEL_M0 = 8'h5E;
   localparam logic [7:0] MASK_SEL_M1 = 8'hA7;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } tx_state_e;

   function automatic logic [7:0] mask_pattern(input logic m0, input logic m1);
      return ({8{m0}} & MASK_SEL_M0) ^ ({8{m1}} & MASK_SEL_M1);
   endfunction

endpackage

// File: rtl/masked_byte_encoder.sv
// Combinational two-share encoder: share0 ^ share1 ^ M(m0,m1) reconstructs data.
module masked_byte_encoder
   import masked_aes_pkg::*;
(
   input  logic [7:0] data,
   input  logic [7:0] rnd,
   input  logic       m0,
   input  logic       m1,
   output logic [7:0] share0,
   output logic [7:0] share1
);

   assign share1 = rnd;
   assign share0 = data ^ mask_pattern(m0, m1) ^ rnd;

endmodule

// File: rtl/masked_state_tx.sv
// Byte-serial transmitter turning a plaintext AES state into masked two-share bytes.
//
//   state | meaning
//   IDLE  | waiting for a block; in_ready high, outputs cleared
//   SEND  | presenting masked byte idx; advances on each out handshake
module masked_state_tx
   import masked_aes_pkg::*;
#(
   parameter  int NBYTES = NBYTES_DEFAULT,
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_data,
   input  logic [1:0]            rnd_mask,
   input  logic [7:0]            rnd_share,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_share0,
   output logic [7:0]            out_share1,
   output logic                  out_m0,
   output logic                  out_m1,
   output logic [IDX_W-1:0]      out_idx,
   output logic                  out_last
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   tx_state_e                 state_q, state_d;
   logic [NBYTES-1:0][7:0]    block_q, block_d;
   logic [1:0]                mask_q, mask_d;
   logic [7:0]                share0_q, share0_d;
   logic [7:0]                share1_q, share1_d;
   logic [IDX_W-1:0]          idx_q, idx_d;

   logic [7:0]                enc_data, enc_share0, enc_share1;
   logic                      enc_m0, enc_m1, load_byte;

   masked_byte_encoder u_enc (
      .data   (enc_data),
      .rnd    (rnd_share),
      .m0     (enc_m0),
      .m1     (enc_m1),
      .share0 (enc_share0),
      .share1 (enc_share1)
   );

   always_comb begin
      state_d   = state_q;
      block_d   = block_q;
      mask_d    = mask_q;
      idx_d     = idx_q;
      share0_d  = share0_q;
      share1_d  = share1_q;
      enc_data  = '0;
      enc_m0    = 1'b0;
      enc_m1    = 1'b0;
      load_byte = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               block_d   = in_data;
               mask_d    = rnd_mask;
               idx_d     = '0;
               enc_data  = in_data[7:0];
               enc_m0    = rnd_mask[0];
               enc_m1    = rnd_mask[1];
               load_byte = 1'b1;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (idx_q == IDX_LAST) begin
                  // Wipe plaintext and shares so nothing lingers between blocks.
                  state_d  = IDLE;
                  block_d  = '0;
                  mask_d   = '0;
                  idx_d    = '0;
                  share0_d = '0;
                  share1_d = '0;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  enc_data  = block_q[idx_d];
                  enc_m0    = mask_q[0];
                  enc_m1    = mask_q[1];
                  load_byte = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load_byte) begin
         share0_d = enc_share0;
         share1_d = enc_share1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         block_q  <= '0;
         mask_q   <= '0;
         share0_q <= '0;
         share1_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         block_q  <= block_d;
         mask_q   <= mask_d;
         share0_q <= share0_d;
         share1_q <= share1_d;
         idx_q    <= idx_d;
      end
   end

   // in_ready is held low while reset is asserted, high in IDLE otherwise.
   assign in_ready   = (state_q == IDLE) && !rst;
   assign out_valid  = (state_q == SEND);
   assign out_share0 = share0_q;
   assign out_share1 = share1_q;
   assign out_m0     = mask_q[0];
   assign out_m1     = mask_q[1];
   assign out_idx    = idx_q;
   assign out_last   = out_valid && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_masked_state_tx.sv
// Randomized self-checking bench for masked_state_tx against a table-driven mask model.
module tb_masked_state_tx;

   localparam int NB = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [8*NB-1:0] in_data = '0;
   logic [1:0]      rnd_mask = '0;
   logic [7:0]      rnd_share = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [7:0]      out_share0, out_share1;
   logic            out_m0, out_m1;
   logic [3:0]      out_idx;
   logic            out_last;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] ob_s0 [NB];
   logic [7:0] ob_s1 [NB];
   logic [7:0] ob_rnd[NB];
   logic [3:0] ob_idx[NB];
   logic       ob_last[NB];
   logic       ob_m0 [NB];
   logic       ob_m1 [NB];
   int         ob_n, ob_cycles, ob_stall_bad;

   masked_state_tx dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rnd_mask   (rnd_mask),
      .rnd_share  (rnd_share),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_share0 (out_share0),
      .out_share1 (out_share1),
      .out_m0     (out_m0),
      .out_m1     (out_m1),
      .out_idx    (out_idx),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   // Mask values as tabulated for {m1,m0}.
   function automatic logic [7:0] ref_mask(input logic [1:0] m);
      case (m)
         2'b01:   return 8'h5E;
         2'b10:   return 8'hA7;
         2'b11:   return 8'hF9;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [8*NB-1:0] d, input int k);
      return d[8*k +: 8];
   endfunction

   function automatic logic [8*NB-1:0] rand_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers one block, then drains it with random backpressure, recording every accepted byte.
   task automatic drive_block(input logic [8*NB-1:0] data, input logic [1:0] m, input int stall_pct,
                              input bit fix_rnd, input logic [7:0] rnd_fix);
      logic [7:0] load_rnd, p0, p1;
      logic [3:0] pidx;
      logic       pl, pm0, pm1;
      bit         stalled;
      int         cyc;
      ob_n = 0; ob_cycles = 0; ob_stall_bad = 0; stalled = 0;
      p0 = '0; p1 = '0; pidx = '0; pl = 0; pm0 = 0; pm1 = 0;
      in_data = data; rnd_mask = m; in_valid = 1'b1;
      rnd_share = fix_rnd ? rnd_fix : 8'($urandom);
      cyc = 0;
      while (!in_ready && cyc < 50) begin tick(); cyc++; end
      load_rnd = rnd_share;
      tick();
      in_valid = 1'b0;
      in_data = rand_block();
      rnd_mask = 2'($urandom);
      cyc = 0;
      while (ob_n < NB && cyc < 400) begin
         if (!out_valid) break;
         if (stalled && ({out_share0, out_share1, out_idx, out_last, out_m0, out_m1} !==
                         {p0, p1, pidx, pl, pm0, pm1}))
            ob_stall_bad++;
         rnd_share = fix_rnd ? rnd_fix : 8'($urandom);
         out_ready = ($urandom_range(99) >= stall_pct);
         if (out_ready) begin
            ob_s0[ob_n] = out_share0; ob_s1[ob_n] = out_share1; ob_rnd[ob_n] = load_rnd;
            ob_idx[ob_n] = out_idx; ob_last[ob_n] = out_last;
            ob_m0[ob_n] = out_m0; ob_m1[ob_n] = out_m1;
            ob_n++;
            load_rnd = rnd_share;
         end
         p0 = out_share0; p1 = out_share1; pidx = out_idx; pl = out_last; pm0 = out_m0; pm1 = out_m1;
         stalled = !out_ready;
         tick();
         cyc++;
      end
      ob_cycles = cyc;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready);
      else n_pass++;
      n_checks++;
      if ({out_valid, out_share0, out_share1, out_m0, out_m1, out_idx, out_last} !== '0)
         $display("FAIL reset_outputs: got %h want 0",
                  {out_valid, out_share0, out_share1, out_m0, out_m1, out_idx, out_last});
      else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after: got %b want 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_fixed_block();
      logic [8*NB-1:0] d;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'(k);
      drive_block(d, 2'b01, 0, 1'b1, 8'h00);
      n_checks++;
      if (ob_n !== NB) $display("FAIL fixed_count: got %0d want %0d", ob_n, NB); else n_pass++;
      n_checks++;
      if (ob_cycles !== NB) $display("FAIL fixed_cycles: got %0d want %0d", ob_cycles, NB); else n_pass++;
      for (int k = 0; k < ob_n; k++) begin
         n_checks++;
         if (ob_idx[k] !== 4'(k)) $display("FAIL fixed_idx: got %0d want %0d", ob_idx[k], k); else n_pass++;
         n_checks++;
         if (ob_s0[k] !== (8'(k) ^ 8'h5E)) $display("FAIL fixed_share0 k=%0d: got %h want %h", k, ob_s0[k], 8'(k) ^ 8'h5E);
         else n_pass++;
         n_checks++;
         if (ob_s1[k] !== 8'h00) $display("FAIL fixed_share1 k=%0d: got %h want 00", k, ob_s1[k]); else n_pass++;
         n_checks++;
         if (ob_last[k] !== (k == NB - 1)) $display("FAIL fixed_last k=%0d: got %b", k, ob_last[k]); else n_pass++;
         n_checks++;
         if ({ob_m1[k], ob_m0[k]} !== 2'b01) $display("FAIL fixed_mask k=%0d: got %b%b want 01", k, ob_m1[k], ob_m0[k]);
         else n_pass++;
      end
      n_checks++;
      if ({in_ready, out_valid, out_m1, out_m0} !== 4'b1000)
         $display("FAIL fixed_return_idle: got %b want 1000", {in_ready, out_valid, out_m1, out_m0});
      else n_pass++;
   endtask

   task automatic test_mask_patterns();
      logic [8*NB-1:0] d;
      logic [1:0] masks [2];
      masks[0] = 2'b10; masks[1] = 2'b11;
      for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'(k);
      for (int i = 0; i < 2; i++) begin
         drive_block(d, masks[i], 0, 1'b0, 8'h00);
         n_checks++;
         if (ob_n !== NB) $display("FAIL mask_count m=%b: got %0d want %0d", masks[i], ob_n, NB); else n_pass++;
         for (int k = 0; k < ob_n; k++) begin
            n_checks++;
            if ((ob_s0[k] ^ ob_s1[k]) !== (8'(k) ^ ref_mask(masks[i])))
               $display("FAIL mask_xor m=%b k=%0d: got %h want %h", masks[i], k, ob_s0[k] ^ ob_s1[k],
                        8'(k) ^ ref_mask(masks[i]));
            else n_pass++;
            n_checks++;
            if (ob_s1[k] !== ob_rnd[k]) $display("FAIL mask_share1 k=%0d: got %h want %h", k, ob_s1[k], ob_rnd[k]);
            else n_pass++;
            n_checks++;
            if ({ob_m1[k], ob_m0[k]} !== masks[i]) $display("FAIL mask_bits k=%0d: got %b%b want %b", k, ob_m1[k], ob_m0[k], masks[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      for (int b = 0; b < 30; b++) begin
         logic [8*NB-1:0] d;
         logic [1:0] m;
         d = rand_block();
         m = 2'($urandom);
         drive_block(d, m, 40, 1'b0, 8'h00);
         n_checks++;
         if (ob_n !== NB) $display("FAIL bp_count: got %0d want %0d", ob_n, NB); else n_pass++;
         n_checks++;
         if (ob_stall_bad !== 0) $display("FAIL bp_stall_stable: got %0d unstable cycles want 0", ob_stall_bad); else n_pass++;
         for (int k = 0; k < ob_n; k++) begin
            n_checks++;
            if (ob_idx[k] !== 4'(k)) $display("FAIL bp_idx: got %0d want %0d", ob_idx[k], k); else n_pass++;
            n_checks++;
            if ((ob_s0[k] ^ ob_s1[k] ^ ref_mask(m)) !== byte_of(d, k))
               $display("FAIL bp_reconstruct k=%0d: got %h want %h", k, ob_s0[k] ^ ob_s1[k] ^ ref_mask(m), byte_of(d, k));
            else n_pass++;
            n_checks++;
            if (ob_s1[k] !== ob_rnd[k]) $display("FAIL bp_share1 k=%0d: got %h want %h", k, ob_s1[k], ob_rnd[k]); else n_pass++;
         end
      end
   endtask

   task automatic test_overlap();
      logic [8*NB-1:0] a, b;
      logic [1:0] ma, mb;
      int got, early, errs, cyc;
      a = rand_block(); b = ~a; ma = 2'b11; mb = 2'b01;
      in_data = a; rnd_mask = ma; in_valid = 1'b1; rnd_share = 8'($urandom);
      tick();
      in_data = b; rnd_mask = mb; out_ready = 1'b1;
      got = 0; early = 0; errs = 0; cyc = 0;
      while (got < NB && cyc < 100) begin
         if (in_ready) early++;
         if (out_valid) begin
            if ((out_idx !== 4'(got)) || ((out_share0 ^ out_share1 ^ ref_mask(ma)) !== byte_of(a, got))) errs++;
            got++;
         end
         rnd_share = 8'($urandom);
         tick();
         cyc++;
      end
      n_checks++;
      if (got !== NB) $display("FAIL overlap_count: got %0d want %0d", got, NB); else n_pass++;
      n_checks++;
      if (early !== 0) $display("FAIL overlap_in_ready_in_send: got %0d cycles want 0", early); else n_pass++;
      n_checks++;
      if (errs !== 0) $display("FAIL overlap_first_block: got %0d bad bytes want 0", errs); else n_pass++;
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) $display("FAIL overlap_gap: got %b want 10", {in_ready, out_valid}); else n_pass++;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, out_idx} !== 5'b1_0000) $display("FAIL overlap_second_start: got %b want 10000", {out_valid, out_idx});
      else n_pass++;
      n_checks++;
      if ((out_share0 ^ out_share1 ^ ref_mask(mb)) !== byte_of(b, 0))
         $display("FAIL overlap_second_byte0: got %h want %h", out_share0 ^ out_share1 ^ ref_mask(mb), byte_of(b, 0));
      else n_pass++;
      cyc = 0;
      while (out_valid && cyc < 40) begin tick(); cyc++; end
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL overlap_drain: got out_valid %b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [8*NB-1:0] d;
      logic [1:0] m;
      d = rand_block(); m = 2'b10;
      in_data = d; rnd_mask = m; in_valid = 1'b1; rnd_share = 8'($urandom);
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin rnd_share = 8'($urandom); tick(); end
      n_checks++;
      if ({out_valid, out_idx} !== 5'b1_0110) $display("FAIL rstmid_pre: got %b want 10110", {out_valid, out_idx}); else n_pass++;
      rst = 1'b1; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, out_share0, out_share1, out_m0, out_m1, out_idx, out_last} !== '0)
         $display("FAIL rstmid_outputs: got %h want 0", {out_valid, out_share0, out_share1, out_m0, out_m1, out_idx, out_last});
      else n_pass++;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++;
      if (dut.block_q !== '0) $display("FAIL rstmid_block_cleared: got %h want 0", dut.block_q); else n_pass++;
      d = rand_block();
      drive_block(d, 2'b01, 0, 1'b0, 8'h00);
      n_checks++;
      if (ob_n !== NB) $display("FAIL rstmid_next_count: got %0d want %0d", ob_n, NB); else n_pass++;
      n_checks++;
      if (ob_idx[0] !== 4'd0) $display("FAIL rstmid_next_idx0: got %0d want 0", ob_idx[0]); else n_pass++;
      n_checks++;
      if ((ob_s0[0] ^ ob_s1[0] ^ 8'h5E) !== byte_of(d, 0))
         $display("FAIL rstmid_next_byte0: got %h want %h", ob_s0[0] ^ ob_s1[0] ^ 8'h5E, byte_of(d, 0));
      else n_pass++;
   endtask

   task automatic test_random_blocks();
      for (int b = 0; b < 1000; b++) begin
         logic [8*NB-1:0] d;
         logic [1:0] m;
         d = rand_block();
         m = 2'($urandom);
         drive_block(d, m, 10, 1'b0, 8'h00);
         n_checks++;
         if (ob_n !== NB) $display("FAIL rand_count blk=%0d: got %0d want %0d", b, ob_n, NB); else n_pass++;
         for (int k = 0; k < ob_n; k++) begin
            n_checks++;
            if ((ob_s0[k] ^ ob_s1[k]) !== (byte_of(d, k) ^ ref_mask(m)))
               $display("FAIL rand_xor blk=%0d k=%0d: got %h want %h", b, k, ob_s0[k] ^ ob_s1[k], byte_of(d, k) ^ ref_mask(m));
            else n_pass++;
            if (m != 2'b00) begin
               n_checks++;
               if ((ob_s0[k] ^ ob_s1[k]) === byte_of(d, k))
                  $display("FAIL rand_plain_leak blk=%0d k=%0d: got %h must differ from %h", b, k, ob_s0[k] ^ ob_s1[k], byte_of(d, k));
               else n_pass++;
            end
         end
         n_checks++;
         if (dut.block_q !== '0) $display("FAIL rand_block_idle blk=%0d: got %h want 0", b, dut.block_q); else n_pass++;
         n_checks++;
         if ({out_m1, out_m0, out_valid} !== 3'b000) $display("FAIL rand_idle_mask blk=%0d: got %b want 000", b, {out_m1, out_m0, out_valid});
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_fixed_block();
      test_mask_patterns();
      test_backpressure();
      test_overlap();
      test_reset_mid();
      test_random_blocks();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
